// File: rtl/jtmx5k_pcm_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtmx5k_pcm_arb                                               |
// | Description : Two-channel ADPCM sample fetcher sharing one ROM port.      |
// |               Each channel keeps a one-entry cache (tag/data/valid).       |
// |               Misses are arbitrated round-robin and fetched through an     |
// |               IDLE -> ISSUE -> WAIT sequence with a fetch timeout.         |
// | Ports       : clk, rst             - system clock, sync active-high reset  |
// |               cha_addr/cs/dout/ok  - channel A request and cached data     |
// |               chb_addr/cs/dout/ok  - channel B request and cached data     |
// |               rom_addr/cs          - shared ROM request (bank bit on [17]) |
// |               rom_data/ok          - shared ROM response                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtmx5k_pcm_arb #(
  parameter logic        BANKA = 1'b0,
  parameter logic        BANKB = 1'b1,
  parameter int unsigned TOW   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] cha_addr,
  input  logic        cha_cs,
  output logic [7:0]  cha_dout,
  output logic        cha_ok,
  input  logic [16:0] chb_addr,
  input  logic        chb_cs,
  output logic [7:0]  chb_dout,
  output logic        chb_ok,
  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok
);

  localparam logic [1:0]     c_IDLE    = 2'd0;
  localparam logic [1:0]     c_ISSUE   = 2'd1;
  localparam logic [1:0]     c_WAIT    = 2'd2;
  localparam logic [TOW-1:0] c_CNT_ONE = {{(TOW-1){1'b0}}, 1'b1};

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;

  // Per-channel cache entries
  logic [16:0]    r_tag_a, r_tag_b;
  logic [7:0]     r_data_a, r_data_b;
  logic           r_vld_a, r_vld_b;
  logic           r_ok_a, r_ok_b;

  // Fetch bookkeeping
  logic           r_ptr;      // round-robin pointer: 0 = A, 1 = B
  logic           r_gnt;      // channel owning the fetch in flight
  logic [16:0]    r_tag;      // address actually issued, used as cache tag
  logic [TOW-1:0] r_cnt;
  logic [17:0]    r_rom_addr;
  logic           r_rom_cs;

  logic           w_hit_a, w_hit_b, w_miss_a, w_miss_b;
  logic [TOW-1:0] w_cnt_inc;
  logic           w_timeout;
  logic           w_issue, w_sel_b, w_fill, w_abort, w_cnt_en;

  assign w_hit_a   = r_vld_a && (r_tag_a == cha_addr);
  assign w_hit_b   = r_vld_b && (r_tag_b == chb_addr);
  assign w_miss_a  = cha_cs && !w_hit_a;
  assign w_miss_b  = chb_cs && !w_hit_b;
  // Timeout fires on the WAIT cycle whose increment reaches all-ones.
  assign w_cnt_inc = r_cnt + c_CNT_ONE;
  assign w_timeout = &w_cnt_inc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_miss_a || w_miss_b) w_state_nxt = c_ISSUE;
      c_ISSUE: w_state_nxt = c_WAIT;    // rom_ok may be stale here; never sampled
      c_WAIT:  if (rom_ok || w_timeout) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_issue  = 1'b0;
    w_sel_b  = 1'b0;
    w_fill   = 1'b0;
    w_abort  = 1'b0;
    w_cnt_en = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_issue = w_miss_a || w_miss_b;
        // B wins when it is the only miss, or both miss and the pointer is on B
        w_sel_b = w_miss_b && (!w_miss_a || r_ptr);
      end
      c_WAIT: begin
        w_cnt_en = 1'b1;
        w_fill   = rom_ok;
        w_abort  = !rom_ok && w_timeout;
      end
      default: ;
    endcase
  end

  // Datapath: request register, timeout counter and cache entries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= 1'b0;
      r_gnt      <= 1'b0;
      r_tag      <= '0;
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_rom_cs   <= 1'b0;
      r_tag_a    <= '0;
      r_tag_b    <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_vld_a    <= 1'b0;
      r_vld_b    <= 1'b0;
      r_ok_a     <= 1'b0;
      r_ok_b     <= 1'b0;
    end else begin
      r_ok_a <= cha_cs && w_hit_a;
      r_ok_b <= chb_cs && w_hit_b;

      if (w_issue) begin
        r_gnt      <= w_sel_b;
        r_ptr      <= !w_sel_b;
        r_tag      <= w_sel_b ? chb_addr : cha_addr;
        r_rom_addr <= w_sel_b ? {BANKB, chb_addr} : {BANKA, cha_addr};
        r_rom_cs   <= 1'b1;
        r_cnt      <= '0;
      end

      if (w_cnt_en) r_cnt <= w_cnt_inc;

      if (w_fill) begin
        r_rom_cs <= 1'b0;
        if (r_gnt) begin
          r_tag_b  <= r_tag;
          r_data_b <= rom_data;
          r_vld_b  <= 1'b1;
        end else begin
          r_tag_a  <= r_tag;
          r_data_a <= rom_data;
          r_vld_a  <= 1'b1;
        end
      end

      if (w_abort) r_rom_cs <= 1'b0;
    end
  end

  assign cha_dout = r_data_a;
  assign chb_dout = r_data_b;
  assign cha_ok   = r_ok_a;
  assign chb_ok   = r_ok_b;
  assign rom_addr = r_rom_addr;
  assign rom_cs   = r_rom_cs;

endmodule
`default_nettype wire

// File: tb/tb_jtmx5k_pcm_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jtmx5k_pcm_arb                                            |
// | Description : Directed self-checking bench for jtmx5k_pcm_arb (TOW = 3).   |
// |               Inputs change and outputs are sampled 1 ns after posedge.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jtmx5k_pcm_arb;

  logic        clk;
  logic        rst;
  logic [16:0] cha_addr, chb_addr;
  logic        cha_cs, chb_cs;
  logic [7:0]  cha_dout, chb_dout;
  logic        cha_ok, chb_ok;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;

  int n_cmp = 0;
  int n_err = 0;

  jtmx5k_pcm_arb #(.BANKA(1'b0), .BANKB(1'b1), .TOW(3)) dut (
    .clk(clk), .rst(rst),
    .cha_addr(cha_addr), .cha_cs(cha_cs), .cha_dout(cha_dout), .cha_ok(cha_ok),
    .chb_addr(chb_addr), .chb_cs(chb_cs), .chb_dout(chb_dout), .chb_ok(chb_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cha_cs = 1'b0; chb_cs = 1'b0; cha_addr = '0; chb_addr = '0;
    rom_ok = 1'b0; rom_data = '0;
    step; step;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    n_cmp++; if (rom_addr !== 18'h0) begin n_err++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    n_cmp++; if (cha_ok !== 1'b0) begin n_err++; $display("FAIL reset_cha_ok: got %b want 0", cha_ok); end
    n_cmp++; if (chb_ok !== 1'b0) begin n_err++; $display("FAIL reset_chb_ok: got %b want 0", chb_ok); end
    n_cmp++; if (cha_dout !== 8'h00) begin n_err++; $display("FAIL reset_cha_dout: got %h want 00", cha_dout); end
    n_cmp++; if (chb_dout !== 8'h00) begin n_err++; $display("FAIL reset_chb_dout: got %h want 00", chb_dout); end
    rst = 1'b0;
  endtask

  task automatic test_single_miss;
    cha_addr = 17'h00123; cha_cs = 1'b1; rom_ok = 1'b1; rom_data = 8'h5A;
    step; // IDLE issues
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL single_cs_issue: got %b want 1", rom_cs); end
    n_cmp++; if (rom_addr !== 18'h00123) begin n_err++; $display("FAIL single_addr: got %h want 00123", rom_addr); end
    n_cmp++; if (cha_ok !== 1'b0) begin n_err++; $display("FAIL single_ok_c1: got %b want 0", cha_ok); end
    step; // ISSUE -> WAIT
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL single_cs_wait: got %b want 1", rom_cs); end
    step; // WAIT fills
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL single_cs_done: got %b want 0", rom_cs); end
    n_cmp++; if (cha_ok !== 1'b0) begin n_err++; $display("FAIL single_ok_c3: got %b want 0", cha_ok); end
    step; // cycle 4
    n_cmp++; if (cha_ok !== 1'b1) begin n_err++; $display("FAIL single_ok_c4: got %b want 1", cha_ok); end
    n_cmp++; if (cha_dout !== 8'h5A) begin n_err++; $display("FAIL single_dout: got %h want 5a", cha_dout); end
    n_cmp++; if (chb_ok !== 1'b0) begin n_err++; $display("FAIL single_chb_ok: got %b want 0", chb_ok); end
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL single_no_refetch: got %b want 0", rom_cs); end
    cha_cs = 1'b0;
    step;
    n_cmp++; if (cha_ok !== 1'b0) begin n_err++; $display("FAIL single_ok_cs_low: got %b want 0", cha_ok); end
  endtask

  task automatic test_simultaneous;
    rst = 1'b1; step; rst = 1'b0;
    cha_addr = 17'h00010; chb_addr = 17'h00020; cha_cs = 1'b1; chb_cs = 1'b1;
    rom_ok = 1'b1; rom_data = 8'hA1;
    step; // pointer starts on A
    n_cmp++; if (rom_addr !== 18'h00010 || rom_cs !== 1'b1) begin n_err++; $display("FAIL simul_first_a: got cs=%b addr=%h want cs=1 addr=00010", rom_cs, rom_addr); end
    step; step;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL simul_gap: got %b want 0", rom_cs); end
    rom_data = 8'hB2;
    step;
    n_cmp++; if (rom_addr !== 18'h20020 || rom_cs !== 1'b1) begin n_err++; $display("FAIL simul_then_b: got cs=%b addr=%h want cs=1 addr=20020", rom_cs, rom_addr); end
    n_cmp++; if (cha_ok !== 1'b1 || cha_dout !== 8'hA1) begin n_err++; $display("FAIL simul_a_data: got ok=%b dout=%h want ok=1 dout=a1", cha_ok, cha_dout); end
    step; step; step;
    n_cmp++; if (chb_ok !== 1'b1 || chb_dout !== 8'hB2) begin n_err++; $display("FAIL simul_b_data: got ok=%b dout=%h want ok=1 dout=b2", chb_ok, chb_dout); end
    n_cmp++; if (cha_ok !== 1'b1 || cha_dout !== 8'hA1) begin n_err++; $display("FAIL simul_a_kept: got ok=%b dout=%h want ok=1 dout=a1", cha_ok, cha_dout); end
    // A-only miss: grant A, pointer moves to B
    cha_addr = 17'h00030; rom_data = 8'hC3;
    step;
    n_cmp++; if (rom_addr !== 18'h00030 || rom_cs !== 1'b1) begin n_err++; $display("FAIL simul_single_a: got cs=%b addr=%h want cs=1 addr=00030", rom_cs, rom_addr); end
    step; step; step;
    n_cmp++; if (cha_ok !== 1'b1 || cha_dout !== 8'hC3) begin n_err++; $display("FAIL simul_single_a_data: got ok=%b dout=%h want ok=1 dout=c3", cha_ok, cha_dout); end
    // Second simultaneous miss, same address on both channels: B first, distinct banks
    cha_addr = 17'h00040; chb_addr = 17'h00040; rom_data = 8'hD4;
    step;
    n_cmp++; if (rom_addr !== 18'h20040 || rom_cs !== 1'b1) begin n_err++; $display("FAIL simul2_first_b: got cs=%b addr=%h want cs=1 addr=20040", rom_cs, rom_addr); end
    step; step;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL simul2_gap: got %b want 0", rom_cs); end
    rom_data = 8'hE5;
    step;
    n_cmp++; if (rom_addr !== 18'h00040 || rom_cs !== 1'b1) begin n_err++; $display("FAIL simul2_then_a: got cs=%b addr=%h want cs=1 addr=00040", rom_cs, rom_addr); end
    step; step; step;
    n_cmp++; if (cha_ok !== 1'b1 || cha_dout !== 8'hE5) begin n_err++; $display("FAIL simul2_a_data: got ok=%b dout=%h want ok=1 dout=e5", cha_ok, cha_dout); end
    n_cmp++; if (chb_ok !== 1'b1 || chb_dout !== 8'hD4) begin n_err++; $display("FAIL simul2_b_data: got ok=%b dout=%h want ok=1 dout=d4", chb_ok, chb_dout); end
  endtask

  // ROM answers two cycles after seeing the new address; during ISSUE its ok
  // line is still high with the previous access's data.
  task automatic test_stale_ok;
    chb_cs = 1'b0; cha_addr = 17'h00041; rom_ok = 1'b1; rom_data = 8'h77;
    step;
    n_cmp++; if (rom_addr !== 18'h00041 || rom_cs !== 1'b1) begin n_err++; $display("FAIL stale_issue: got cs=%b addr=%h want cs=1 addr=00041", rom_cs, rom_addr); end
    step; // ISSUE passed with stale ok
    rom_ok = 1'b0;
    n_cmp++; if (cha_dout !== 8'hE5) begin n_err++; $display("FAIL stale_not_captured: got %h want e5", cha_dout); end
    step;
    n_cmp++; if (rom_cs !== 1'b1 || cha_dout !== 8'hE5) begin n_err++; $display("FAIL stale_still_wait: got cs=%b dout=%h want cs=1 dout=e5", rom_cs, cha_dout); end
    rom_ok = 1'b1; rom_data = 8'h88;
    step; step;
    n_cmp++; if (cha_ok !== 1'b1 || cha_dout !== 8'h88) begin n_err++; $display("FAIL stale_new_data: got ok=%b dout=%h want ok=1 dout=88", cha_ok, cha_dout); end
  endtask

  task automatic test_addr_change;
    cha_addr = 17'h00100; rom_ok = 1'b0;
    step;
    n_cmp++; if (rom_addr !== 18'h00100) begin n_err++; $display("FAIL chg_issue: got %h want 00100", rom_addr); end
    step;
    cha_addr = 17'h00101; rom_ok = 1'b1; rom_data = 8'h99;
    step; // fill stored under tag 00100
    n_cmp++; if (cha_ok !== 1'b0 || rom_cs !== 1'b0) begin n_err++; $display("FAIL chg_fill: got ok=%b cs=%b want ok=0 cs=0", cha_ok, rom_cs); end
    step;
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 18'h00101) begin n_err++; $display("FAIL chg_refetch: got cs=%b addr=%h want cs=1 addr=00101", rom_cs, rom_addr); end
    n_cmp++; if (cha_ok !== 1'b0) begin n_err++; $display("FAIL chg_ok_low: got %b want 0", cha_ok); end
    rom_data = 8'hAB;
    step; step;
    n_cmp++; if (cha_ok !== 1'b0) begin n_err++; $display("FAIL chg_ok_low2: got %b want 0", cha_ok); end
    step;
    n_cmp++; if (cha_ok !== 1'b1 || cha_dout !== 8'hAB) begin n_err++; $display("FAIL chg_new_data: got ok=%b dout=%h want ok=1 dout=ab", cha_ok, cha_dout); end
  endtask

  task automatic test_timeout;
    cha_addr = 17'h00200; rom_ok = 1'b0;
    // issue cycle, ISSUE->WAIT, then 6 WAIT edges still holding rom_cs
    for (int i = 1; i <= 8; i++) begin
      step;
      n_cmp++; if (rom_cs !== 1'b1 || cha_ok !== 1'b0) begin n_err++; $display("FAIL to_hold_%0d: got cs=%b ok=%b want cs=1 ok=0", i, rom_cs, cha_ok); end
    end
    step; // 7th WAIT edge times out
    n_cmp++; if (rom_cs !== 1'b0 || cha_ok !== 1'b0) begin n_err++; $display("FAIL to_drop: got cs=%b ok=%b want cs=0 ok=0", rom_cs, cha_ok); end
    step;
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 18'h00200) begin n_err++; $display("FAIL to_retry: got cs=%b addr=%h want cs=1 addr=00200", rom_cs, rom_addr); end
  endtask

  task automatic test_reset_mid_fetch;
    step; // now in WAIT of the retry
    rst = 1'b1; rom_ok = 1'b1; rom_data = 8'h3C;
    step;
    n_cmp++; if (rom_cs !== 1'b0 || cha_ok !== 1'b0 || chb_ok !== 1'b0) begin n_err++; $display("FAIL rstmid_outs: got cs=%b aok=%b bok=%b want all 0", rom_cs, cha_ok, chb_ok); end
    n_cmp++; if (cha_dout !== 8'h00) begin n_err++; $display("FAIL rstmid_no_fill: got %h want 00", cha_dout); end
    rst = 1'b0;
    step;
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 18'h00200) begin n_err++; $display("FAIL rstmid_reissue: got cs=%b addr=%h want cs=1 addr=00200", rom_cs, rom_addr); end
    step; step; step;
    n_cmp++; if (cha_ok !== 1'b1 || cha_dout !== 8'h3C) begin n_err++; $display("FAIL rstmid_data: got ok=%b dout=%h want ok=1 dout=3c", cha_ok, cha_dout); end
    n_cmp++; if (chb_dout !== 8'h00) begin n_err++; $display("FAIL rstmid_b_clear: got %h want 00", chb_dout); end
  endtask

  initial begin
    test_reset;
    test_single_miss;
    test_simultaneous;
    test_stale_ok;
    test_addr_change;
    test_timeout;
    test_reset_mid_fetch;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
